controle_multiciclo: RTL and testbench

//  Multi-cycle sequencer for the RV32I subset datapath: lw, sw, addi, add, sub, xor, srl, and, or, beq.

---
 rtl/controle_multiciclo_if.sv | 32 +++
 rtl/controle_multiciclo.sv | 192 +++++++++++++++++++
 tb/tb_controle_multiciclo.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/controle_multiciclo_if.sv
// Control bundle between the multi-cycle sequencer (master) and the RV32I datapath/memory (slave).
interface controle_multiciclo_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_src;
  logic       ir_write;
  logic       iord;
  logic       memread;
  logic       memwrite;
  logic       regiwrite;
  logic       memtoreg;
  logic       alusrc;
  logic [3:0] alucontrol;
  logic       instr_done;
  logic       fault;

  modport master (
    input  opcode, funct3, funct7, zero, mem_ready,
    output pc_write, pc_src, ir_write, iord, memread, memwrite,
           regiwrite, memtoreg, alusrc, alucontrol, instr_done, fault
  );

  modport slave (
    output opcode, funct3, funct7, zero, mem_ready,
    input  pc_write, pc_src, ir_write, iord, memread, memwrite,
           regiwrite, memtoreg, alusrc, alucontrol, instr_done, fault
  );
endinterface

// File: rtl/controle_multiciclo.sv
// Multi-cycle control FSM for the RV32I subset (lw, sw, addi, add, sub, xor, srl, and, or, beq).
// Optional macro ILLEGAL_TRAP_EN: unsupported instructions trap to FAULT instead of retiring as NOP.
module controle_multiciclo #(
  parameter int unsigned MEM_WAIT_MAX = 8,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  controle_multiciclo_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT
  } state_t;

  typedef enum logic [3:0] {
    C_ILL, C_LW, C_SW, C_ADDI, C_BEQ, C_ADD, C_SUB, C_XOR, C_SRL, C_OR, C_AND
  } class_t;

  state_t             state_q, state_d;
  class_t             class_q, class_d, dec_class;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mem_last;
  logic [3:0]         alu_sel;
  logic               asrc_sel;
  logic               unused_bits;

  logic pc_write, pc_src, ir_write, iord, memread, memwrite;
  logic regiwrite, memtoreg, alusrc, instr_done, fault;
  logic [3:0] alucontrol;

  assign unused_bits = ^{bus.opcode[3:0], bus.funct7[6], bus.funct7[4:0]};

  always_comb begin
    dec_class = C_ILL;
    case (bus.opcode[6:4])
      3'b000: dec_class = C_LW;
      3'b001: dec_class = C_ADDI;
      3'b010: dec_class = C_SW;
      3'b110: dec_class = C_BEQ;
      3'b011: begin
        case (bus.funct3)
          3'b000:  dec_class = bus.funct7[5] ? C_SUB : C_ADD;
          3'b100:  dec_class = C_XOR;
          3'b101:  dec_class = C_SRL;
          3'b110:  dec_class = C_OR;
          3'b111:  dec_class = C_AND;
          default: dec_class = C_ILL;
        endcase
      end
      default: dec_class = C_ILL;
    endcase
  end

  // A cycle without mem_ready at count MAX-1 is the MAX-th wait cycle; mem_ready in that cycle still completes.
  assign mem_last = (cnt_q == CNT_W'(MEM_WAIT_MAX - 1));

  always_comb begin
    state_d = state_q;
    class_d = class_q;
    cnt_d   = '0;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ready)  state_d = S_DECODE;
        else if (mem_last)  state_d = S_FAULT;
        else                cnt_d   = cnt_q + 1'b1;
      end
      S_DECODE: begin
        class_d = dec_class;
        if (dec_class == C_ILL) begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_FAULT;
`else
          state_d = S_FETCH;
`endif
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (class_q)
          C_BEQ:       state_d = S_FETCH;
          C_LW, C_SW:  state_d = S_MEM;
          default:     state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (bus.mem_ready)  state_d = (class_q == C_LW) ? S_WB : S_FETCH;
        else if (mem_last)  state_d = S_FAULT;
        else                cnt_d   = cnt_q + 1'b1;
      end
      S_WB:    state_d = S_FETCH;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      class_q <= C_ILL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    alu_sel = 4'b0000;
    case (class_q)
      C_AND:             alu_sel = 4'b0000;
      C_OR:              alu_sel = 4'b0001;
      C_ADD, C_LW, C_SW: alu_sel = 4'b0010;
      C_ADDI:            alu_sel = 4'b0011;
      C_XOR:             alu_sel = 4'b0100;
      C_SRL:             alu_sel = 4'b0101;
      C_SUB, C_BEQ:      alu_sel = 4'b0110;
      default:           alu_sel = 4'b0000;
    endcase
    asrc_sel = (class_q == C_LW) || (class_q == C_SW) || (class_q == C_ADDI);
  end

  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    regiwrite  = 1'b0;
    memtoreg   = 1'b0;
    alusrc     = 1'b0;
    alucontrol = 4'b0000;
    instr_done = 1'b0;
    fault      = 1'b0;
    case (state_q)
      S_FETCH: begin
        memread  = 1'b1;
        ir_write = bus.mem_ready;
        pc_write = bus.mem_ready;
      end
      S_DECODE: begin
`ifndef ILLEGAL_TRAP_EN
        instr_done = (dec_class == C_ILL);
`endif
      end
      S_EXEC: begin
        alucontrol = alu_sel;
        alusrc     = asrc_sel;
        if (class_q == C_BEQ) begin
          pc_write   = bus.zero;
          pc_src     = 1'b1;
          instr_done = 1'b1;
        end
      end
      S_MEM: begin
        alucontrol = alu_sel;
        alusrc     = asrc_sel;
        iord       = 1'b1;
        memread    = (class_q == C_LW);
        memwrite   = (class_q == C_SW);
        instr_done = (class_q == C_SW) && bus.mem_ready;
      end
      S_WB: begin
        alucontrol = alu_sel;
        alusrc     = asrc_sel;
        regiwrite  = 1'b1;
        memtoreg   = (class_q == C_LW);
        instr_done = 1'b1;
      end
      S_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

  assign bus.pc_write   = pc_write;
  assign bus.pc_src     = pc_src;
  assign bus.ir_write   = ir_write;
  assign bus.iord       = iord;
  assign bus.memread    = memread;
  assign bus.memwrite   = memwrite;
  assign bus.regiwrite  = regiwrite;
  assign bus.memtoreg   = memtoreg;
  assign bus.alusrc     = alusrc;
  assign bus.alucontrol = alucontrol;
  assign bus.instr_done = instr_done;
  assign bus.fault      = fault;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Scoreboard bench for controle_multiciclo: per-cycle expected control vectors queued with stimulus.
module tb_controle_multiciclo;

  logic clk;
  logic rst;
  controle_multiciclo_if bus_if ();

  controle_multiciclo #(.MEM_WAIT_MAX(8), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.master)
  );

  // {pc_write, pc_src, ir_write, iord, memread, memwrite, regiwrite, memtoreg, alusrc, alucontrol[3:0], instr_done, fault}
  logic [14:0] obs;
  assign obs = {bus_if.pc_write, bus_if.pc_src, bus_if.ir_write, bus_if.iord, bus_if.memread,
                bus_if.memwrite, bus_if.regiwrite, bus_if.memtoreg, bus_if.alusrc,
                bus_if.alucontrol, bus_if.instr_done, bus_if.fault};

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [1:0]  st_q[$];
  logic [14:0] exp_q[$];

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] alu;
    logic       asrc;
  } alu_case_t;

  localparam alu_case_t TBL [6] = '{
    '{7'b0110011, 3'b000, 7'b0100000, 4'b0110, 1'b0},
    '{7'b0110011, 3'b100, 7'b0000000, 4'b0100, 1'b0},
    '{7'b0110011, 3'b101, 7'b0000000, 4'b0101, 1'b0},
    '{7'b0110011, 3'b110, 7'b0000000, 4'b0001, 1'b0},
    '{7'b0110011, 3'b111, 7'b0000000, 4'b0000, 1'b0},
    '{7'b0010011, 3'b000, 7'b0000000, 4'b0011, 1'b1}
  };

  function automatic logic [14:0] ev(input logic pcw, pcs, irw, iord, mr, mw, rw, m2r, asrc,
                                     input logic [3:0] alu, input logic done, flt);
    return {pcw, pcs, irw, iord, mr, mw, rw, m2r, asrc, alu, done, flt};
  endfunction

  localparam logic [14:0] V_ZERO  = 15'h0000;
  localparam logic [14:0] V_FWAIT = 15'h0400;
  localparam logic [14:0] V_FRDY  = 15'h5400;
  localparam logic [14:0] V_FAULT = 15'h0001;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "time limit");
  end

  task automatic push(input logic z, input logic rdy, input logic [14:0] e);
    st_q.push_back({z, rdy});
    exp_q.push_back(e);
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    bus_if.opcode = op;
    bus_if.funct3 = f3;
    bus_if.funct7 = f7;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_if.zero = 1'b0;
    bus_if.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [14:0] e;
    int unsigned cyc;
    rst = 1'b1;
    set_instr(7'b0110011, 3'b000, 7'b0000000);
    push(1'b0, 1'b1, V_ZERO);
    push(1'b0, 1'b1, V_ZERO);
    cyc = 0;
    @(negedge clk);
    while (st_q.size() != 0) begin
      {bus_if.zero, bus_if.mem_ready} = st_q.pop_front();
      #2;
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL reset_hold cyc%0d obs=%h exp=%h", cyc, obs, e);
      end
      cyc++;
      @(negedge clk);
    end
    rst = 1'b0;
    push(1'b0, 1'b1, V_ZERO);
    push(1'b0, 1'b0, V_FWAIT);
    push(1'b0, 1'b1, V_FRDY);
    push(1'b0, 1'b1, V_ZERO);
    cyc = 0;
    while (st_q.size() != 0) begin
      {bus_if.zero, bus_if.mem_ready} = st_q.pop_front();
      #2;
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL fetch_seq cyc%0d obs=%h exp=%h", cyc, obs, e);
      end
      cyc++;
      @(negedge clk);
    end
    // Now in EXEC of add; assert reset asynchronously mid-cycle.
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (obs !== V_ZERO) begin
      fails++;
      $display("FAIL reset_async obs=%h exp=%h", obs, V_ZERO);
    end
    @(negedge clk);
    bus_if.mem_ready = 1'b1;
    #1;
    tests++;
    if (obs !== V_ZERO) begin
      fails++;
      $display("FAIL reset_after_edge obs=%h exp=%h", obs, V_ZERO);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    logic [14:0] e;
    int unsigned cyc;
    do_reset();
    set_instr(7'b0110011, 3'b000, 7'b0000000);
    push(1'b0, 1'b1, V_ZERO);
    push(1'b0, 1'b1, V_FRDY);
    push(1'b0, 1'b1, V_ZERO);
    push(1'b0, 1'b1, ev(0,0,0,0,0,0,0,0,0, 4'b0010, 0,0));
    push(1'b0, 1'b1, ev(0,0,0,0,0,0,1,0,0, 4'b0010, 1,0));
    push(1'b0, 1'b0, V_FWAIT);
    cyc = 0;
    while (st_q.size() != 0) begin
      {bus_if.zero, bus_if.mem_ready} = st_q.pop_front();
      #2;
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL add cyc%0d obs=%h exp=%h", cyc, obs, e);
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [14:0] e;
    int unsigned cyc;
    do_reset();
    push(1'b0, 1'b1, V_ZERO);
    for (int i = 0; i < 6; i++) begin
      set_instr(TBL[i].op, TBL[i].f3, TBL[i].f7);
      push(1'b0, 1'b1, V_FRDY);
      push(1'b0, 1'b1, V_ZERO);
      push(1'b0, 1'b1, ev(0,0,0,0,0,0,0,0,TBL[i].asrc, TBL[i].alu, 0,0));
      push(1'b0, 1'b1, ev(0,0,0,0,0,0,1,0,TBL[i].asrc, TBL[i].alu, 1,0));
      cyc = 0;
      while (st_q.size() != 0) begin
        {bus_if.zero, bus_if.mem_ready} = st_q.pop_front();
        #2;
        e = exp_q.pop_front();
        tests++;
        if (obs !== e) begin
          fails++;
          $display("FAIL alu_op%0d cyc%0d obs=%h exp=%h", i, cyc, obs, e);
        end
        cyc++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_lw_sw();
    logic [14:0] e;
    int unsigned cyc;
    do_reset();
    set_instr(7'b0000011, 3'b010, 7'b0000000);
    push(1'b0, 1'b1, V_ZERO);
    push(1'b0, 1'b1, V_FRDY);
    push(1'b0, 1'b1, V_ZERO);
    push(1'b0, 1'b1, ev(0,0,0,0,0,0,0,0,1, 4'b0010, 0,0));
    for (int i = 0; i < 3; i++) push(1'b0, 1'b0, ev(0,0,0,1,1,0,0,0,1, 4'b0010, 0,0));
    push(1'b0, 1'b1, ev(0,0,0,1,1,0,0,0,1, 4'b0010, 0,0));
    push(1'b0, 1'b1, ev(0,0,0,0,0,0,1,1,1, 4'b0010, 1,0));
    // sw follows directly; IR fields switch during its fetch.
    push(1'b0, 1'b1, V_FRDY);
    push(1'b0, 1'b1, V_ZERO);
    push(1'b0, 1'b1, ev(0,0,0,0,0,0,0,0,1, 4'b0010, 0,0));
    push(1'b0, 1'b0, ev(0,0,0,1,0,1,0,0,1, 4'b0010, 0,0));
    push(1'b0, 1'b1, ev(0,0,0,1,0,1,0,0,1, 4'b0010, 1,0));
    push(1'b0, 1'b0, V_FWAIT);
    cyc = 0;
    while (st_q.size() != 0) begin
      if (cyc == 9) set_instr(7'b0100011, 3'b010, 7'b0000000);
      {bus_if.zero, bus_if.mem_ready} = st_q.pop_front();
      #2;
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL lw_sw cyc%0d obs=%h exp=%h", cyc, obs, e);
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_beq();
    logic [14:0] e;
    int unsigned cyc;
    do_reset();
    set_instr(7'b1100011, 3'b000, 7'b0000000);
    push(1'b0, 1'b1, V_ZERO);
    push(1'b0, 1'b1, V_FRDY);
    push(1'b0, 1'b1, V_ZERO);
    push(1'b1, 1'b1, ev(1,1,0,0,0,0,0,0,0, 4'b0110, 1,0));
    push(1'b0, 1'b1, V_FRDY);
    push(1'b0, 1'b1, V_ZERO);
    push(1'b0, 1'b1, ev(0,1,0,0,0,0,0,0,0, 4'b0110, 1,0));
    push(1'b0, 1'b0, V_FWAIT);
    cyc = 0;
    while (st_q.size() != 0) begin
      {bus_if.zero, bus_if.mem_ready} = st_q.pop_front();
      #2;
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL beq cyc%0d obs=%h exp=%h", cyc, obs, e);
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    logic [14:0] e;
    int unsigned cyc;
    do_reset();
    set_instr(7'b0110011, 3'b000, 7'b0000000);
    push(1'b0, 1'b1, V_ZERO);
    for (int i = 0; i < 8; i++) push(1'b0, 1'b0, V_FWAIT);
    for (int i = 0; i < 3; i++) push(1'b0, 1'b1, V_FAULT);
    cyc = 0;
    while (st_q.size() != 0) begin
      {bus_if.zero, bus_if.mem_ready} = st_q.pop_front();
      #2;
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL fetch_timeout cyc%0d obs=%h exp=%h", cyc, obs, e);
      end
      cyc++;
      @(negedge clk);
    end
    // mem_ready on the last allowed wait cycle completes the fetch; then lw times out in MEM.
    do_reset();
    push(1'b0, 1'b1, V_ZERO);
    for (int i = 0; i < 7; i++) push(1'b0, 1'b0, V_FWAIT);
    push(1'b0, 1'b1, V_FRDY);
    push(1'b0, 1'b1, V_ZERO);
    push(1'b0, 1'b1, ev(0,0,0,0,0,0,0,0,0, 4'b0010, 0,0));
    push(1'b0, 1'b1, ev(0,0,0,0,0,0,1,0,0, 4'b0010, 1,0));
    push(1'b0, 1'b1, V_FRDY);
    push(1'b0, 1'b1, V_ZERO);
    push(1'b0, 1'b1, ev(0,0,0,0,0,0,0,0,1, 4'b0010, 0,0));
    for (int i = 0; i < 8; i++) push(1'b0, 1'b0, ev(0,0,0,1,1,0,0,0,1, 4'b0010, 0,0));
    push(1'b0, 1'b1, V_FAULT);
    cyc = 0;
    while (st_q.size() != 0) begin
      if (cyc == 11) set_instr(7'b0000011, 3'b010, 7'b0000000);
      {bus_if.zero, bus_if.mem_ready} = st_q.pop_front();
      #2;
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL wait_boundary cyc%0d obs=%h exp=%h", cyc, obs, e);
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    logic [14:0] e;
    int unsigned cyc;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      if (k == 0) set_instr(7'b1110011, 3'b000, 7'b0000000);
      else        set_instr(7'b0110011, 3'b001, 7'b0000000);
      push(1'b0, 1'b1, V_ZERO);
      push(1'b0, 1'b1, V_FRDY);
`ifdef ILLEGAL_TRAP_EN
      push(1'b0, 1'b1, V_ZERO);
      push(1'b0, 1'b1, V_FAULT);
      push(1'b0, 1'b1, V_FAULT);
`else
      push(1'b0, 1'b1, ev(0,0,0,0,0,0,0,0,0, 4'b0000, 1,0));
      push(1'b0, 1'b0, V_FWAIT);
      push(1'b0, 1'b1, V_FRDY);
`endif
      cyc = 0;
      while (st_q.size() != 0) begin
        {bus_if.zero, bus_if.mem_ready} = st_q.pop_front();
        #2;
        e = exp_q.pop_front();
        tests++;
        if (obs !== e) begin
          fails++;
          $display("FAIL illegal%0d cyc%0d obs=%h exp=%h", k, cyc, obs, e);
        end
        cyc++;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus_if.zero = 1'b0;
    bus_if.mem_ready = 1'b0;
    set_instr(7'b0, 3'b0, 7'b0);
    test_reset();
    test_add();
    test_back_to_back();
    test_lw_sw();
    test_beq();
    test_timeout();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
